// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: shifts a latched parallel pattern out MSB-first, one bit
// per clock, for 1..WIDTH bits and repeat+1 passes. It also keeps a running
// count of overlapping "1101" windows in the emitted stream. This count is the
// golden hit total for a downstream sequence detector.
//
// Handshake: i_start is a request that has no ready signal. It is accepted only
// on an edge where the block is idle and i_len is in 1..WIDTH. o_busy high means
// requests are being ignored. An acceptance is visible as o_busy rising.
// o_done pulses for one cycle after the last bit. A request held through that
// cycle is accepted at its closing edge.
module serial_pattern_tx #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5,
    parameter int REP_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_pattern,
    input  logic [LEN_W-1:0] i_len,
    input  logic [REP_W-1:0] i_repeat,
    output logic             o_out,
    output logic             o_out_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic [7:0]       o_match_cnt,
    output logic             o_state
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_pattern;
    logic [IDX_W-1:0]   r_len_m1;    // latched len-1, the reload index
    logic [REP_W-1:0]   r_repeat;
    logic [IDX_W-1:0]   r_idx;       // index of the bit currently on o_out
    logic [REP_W-1:0]   r_pass;
    logic [2:0]         r_hist;      // last three emitted bits, newest in [0]
    logic [7:0]         r_match_cnt;
    logic               r_out;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_done;

    logic               w_len_ok;
    logic [IDX_W-1:0]   w_start_idx;
    logic               w_start_bit;
    logic               w_last;
    logic [IDX_W-1:0]   w_next_idx;
    logic [REP_W-1:0]   w_next_pass;
    logic               w_next_bit;
    logic               w_hit;

    // Next-bit selection and "1101" window detection for the shifting datapath
    always_comb begin
        w_len_ok    = (i_len != '0) && (i_len <= LEN_MAX);
        w_start_idx = IDX_W'(i_len - 1'b1);
        w_start_bit = i_pattern[w_start_idx];
        w_last      = (r_idx == '0) && (r_pass == r_repeat);
        w_next_idx  = r_idx - 1'b1;
        w_next_pass = r_pass;
        if (r_idx == '0) begin
            w_next_idx  = r_len_m1;
            w_next_pass = r_pass + 1'b1;
        end
        w_next_bit  = r_pattern[w_next_idx];
        w_hit       = ({r_hist, w_next_bit} == 4'b1101);
    end

    // Control FSM with registered outputs. The first bit is driven on the accept edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_pattern   <= '0;
            r_len_m1    <= '0;
            r_repeat    <= '0;
            r_idx       <= '0;
            r_pass      <= '0;
            r_hist      <= '0;
            r_match_cnt <= '0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start && w_len_ok) begin
                        r_state     <= SHIFT;
                        r_pattern   <= i_pattern;
                        r_len_m1    <= w_start_idx;
                        r_repeat    <= i_repeat;
                        r_idx       <= w_start_idx;
                        r_pass      <= '0;
                        // A single bit can never complete a 4-bit match.
                        r_hist      <= {2'b00, w_start_bit};
                        r_match_cnt <= '0;
                        r_out       <= w_start_bit;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_last) begin
                        r_state     <= IDLE;
                        r_out       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_idx  <= w_next_idx;
                        r_pass <= w_next_pass;
                        r_out  <= w_next_bit;
                        r_hist <= {r_hist[1:0], w_next_bit};
                        if (w_hit && (r_match_cnt != 8'hFF)) begin
                            r_match_cnt <= r_match_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_match_cnt = r_match_cnt;
    assign o_state     = r_state;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx. Directed table vectors with hand-written streams,
// corner sequences, and randomized transactions checked against a stream model.
module tb_serial_pattern_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic [3:0]  rep;
  logic        out;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic [7:0]  match_cnt;
  logic        state;

  int vectors     = 0;
  int miscompares = 0;
  int exp_last_cnt = 0;

  serial_pattern_tx #(.WIDTH(16), .LEN_W(5), .REP_W(4)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_pattern   (pattern),
    .i_len       (len),
    .i_repeat    (rep),
    .o_out       (out),
    .o_out_valid (out_valid),
    .o_busy      (busy),
    .o_done      (done),
    .o_match_cnt (match_cnt),
    .o_state     (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compares {out, out_valid, busy, done, match_cnt} in the current cycle
  task automatic expect_cycle(input string name, input logic e_out, input logic e_valid,
                              input logic e_busy, input logic e_done, input int e_cnt);
    logic [7:0] c;
    c = e_cnt[7:0];
    check(name, {20'd0, out, out_valid, busy, done, match_cnt},
          {20'd0, e_out, e_valid, e_busy, e_done, c});
  endtask

  // Runs one transaction and checks every cycle against a stream model. The
  // model expands the pattern into a bit list and counts 1101 windows over it.
  task automatic run_txn(input logic [15:0] pat, input logic [4:0] l, input logic [3:0] r,
                         input bit scramble, output logic [31:0] obs_stream, output int obs_cnt);
    logic q[$];
    int   cnt_q[$];
    int   cnt;
    int   n;
    q.delete();
    cnt_q.delete();
    for (int p = 0; p <= int'(r); p++)
      for (int i = int'(l) - 1; i >= 0; i--)
        q.push_back(pat[i]);
    n = q.size();
    cnt = 0;
    for (int j = 0; j < n; j++) begin
      if (j >= 3 && q[j-3] && q[j-2] && !q[j-1] && q[j])
        cnt = (cnt == 255) ? 255 : cnt + 1;
      cnt_q.push_back(cnt);
    end
    pattern = pat;
    len     = l;
    rep     = r;
    start   = 1'b1;
    tick();
    start = 1'b0;
    obs_stream = '0;
    for (int j = 0; j < n; j++) begin
      obs_stream = {obs_stream[30:0], out};
      expect_cycle("txn_bit", q[j], 1'b1, 1'b1, 1'b0, cnt_q[j]);
      if (scramble) begin
        start   = 1'($urandom_range(0, 1));
        pattern = 16'($urandom);
        len     = 5'($urandom_range(0, 31));
        rep     = 4'($urandom);
      end
      tick();
    end
    start = 1'b0;
    expect_cycle("txn_done", 1'b0, 1'b0, 1'b0, 1'b1, cnt);
    obs_cnt = int'(match_cnt);
    tick();
    expect_cycle("txn_post", 1'b0, 1'b0, 1'b0, 1'b0, cnt);
    exp_last_cnt = cnt;
  endtask

  typedef struct {
    logic [15:0] pattern;
    logic [4:0]  len;
    logic [3:0]  rep;
    logic [31:0] exp_stream;
    int          exp_cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [31:0] obs_s;
    int          obs_c;

    tbl[0] = '{16'h000D, 5'd4,  4'd0, 32'b1101,         1};
    tbl[1] = '{16'h006D, 5'd8,  4'd0, 32'b01101101,     2};
    tbl[2] = '{16'h000D, 5'd4,  4'd2, 32'b110111011101, 3};
    tbl[3] = '{16'hFFFF, 5'd16, 4'd0, 32'h0000FFFF,     0};
    tbl[4] = '{16'h0001, 5'd1,  4'd3, 32'b1111,         0};
    tbl[5] = '{16'hDDDD, 5'd16, 4'd0, 32'h0000DDDD,     4};
    tbl[6] = '{16'hABCD, 5'd4,  4'd0, 32'b1101,         1};

    // reset
    reset = 1'b1; start = 1'b0; pattern = '0; len = '0; rep = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    expect_cycle("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("reset_fsm", {31'd0, state}, 32'd0);

    // illegal lengths after reset
    foreach (tbl[i]) ;
    for (int k = 0; k < 3; k++) begin
      pattern = 16'hDDDD;
      rep = 4'd1;
      len = (k == 0) ? 5'd0 : ((k == 1) ? 5'd17 : 5'd31);
      start = 1'b1;
      tick();
      expect_cycle("illegal_len", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
    start = 1'b0;
    tick();
    expect_cycle("illegal_idle", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // table vectors
    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].pattern, tbl[i].len, tbl[i].rep, 1'b0, obs_s, obs_c);
      check("tbl_stream", obs_s, tbl[i].exp_stream);
      check("tbl_count", obs_c, tbl[i].exp_cnt);
    end

    // illegal start holds the previous count
    len = 5'd0; pattern = 16'h000D; start = 1'b1;
    tick();
    start = 1'b0;
    expect_cycle("illegal_hold", 1'b0, 1'b0, 1'b0, 1'b0, exp_last_cnt);

    // start and inputs toggled mid-shift are ignored
    run_txn(16'h006D, 5'd8, 4'd0, 1'b1, obs_s, obs_c);
    check("busy_start_stream", obs_s, 32'b01101101);
    check("busy_start_count", obs_c, 2);

    // reset during shift
    pattern = 16'hDDDD; len = 5'd16; rep = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    expect_cycle("rst_mid_b1", 1'b1, 1'b1, 1'b1, 1'b0, 0);
    tick();
    expect_cycle("rst_mid_b2", 1'b1, 1'b1, 1'b1, 1'b0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_cycle("rst_mid_abort", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_cycle("rst_mid_nodone", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
    run_txn(16'h000D, 5'd4, 4'd0, 1'b0, obs_s, obs_c);
    check("rst_then_txn", obs_c, 1);

    // back-to-back with start held high
    pattern = 16'h000D; len = 5'd4; rep = 4'd0; start = 1'b1;
    tick();
    for (int t = 0; t < 2; t++) begin
      expect_cycle("b2b_bit0", 1'b1, 1'b1, 1'b1, 1'b0, 0);
      tick();
      expect_cycle("b2b_bit1", 1'b1, 1'b1, 1'b1, 1'b0, 0);
      tick();
      expect_cycle("b2b_bit2", 1'b0, 1'b1, 1'b1, 1'b0, 0);
      tick();
      expect_cycle("b2b_bit3", 1'b1, 1'b1, 1'b1, 1'b0, 1);
      tick();
      expect_cycle("b2b_done", 1'b0, 1'b0, 1'b0, 1'b1, 1);
      if (t == 1) start = 1'b0;
      tick();
    end
    expect_cycle("b2b_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1);

    // randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      logic [15:0] p;
      logic [4:0]  l;
      logic [3:0]  r;
      p = 16'($urandom);
      if ($urandom_range(0, 2) == 0) p = 16'hDB6D ^ 16'($urandom_range(0, 3));
      l = 5'($urandom_range(1, 16));
      r = 4'($urandom_range(0, 3));
      run_txn(p, l, r, 1'($urandom_range(0, 1)), obs_s, obs_c);
    end
    // longest transaction
    run_txn(16'hDB6D, 5'd16, 4'd15, 1'b1, obs_s, obs_c);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial bit-pattern transmitter that drives a single-bit stream into the sequence detectors one bit per clock. A parallel pattern of programmable length is latched on a start request and shifted out MSB-first, optionally repeated. A built-in overlapping "1101" match counter tracks the emitted stream, so each transaction carries a golden hit count that checks the detector's `out` pulses on the same bench or board.

## Interface
- `WIDTH`, 16: maximum pattern length in bits (≥4).
- `LEN_W`, 5: width of `len`; must represent `WIDTH`.
- `REP_W`, 4: width of `repeat`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: transaction request, sampled only in IDLE.
- `pattern` in WIDTH: bits [len-1:0] are transmitted; upper bits ignored.
- `len` in LEN_W: pattern length, legal 1..WIDTH.
- `repeat` in REP_W: extra passes; total passes = repeat+1.
- `out` out 1: serial data bit, the detector's `in`.
- `out_valid` out 1: high while `out` carries a pattern bit.
- `busy` out 1: high from the start-accept edge until the last bit ends.
- `done` out 1: one-cycle pulse after the last bit.
- `match_cnt` out 8: overlapping "1101" count in the current/last transaction, saturating at 255.

## Operation
- States: IDLE, SHIFT.
- **IDLE → SHIFT**
  - Taken when `start`=1 and 1 ≤ `len` ≤ WIDTH.
  - Latches `pattern`, `len` and `repeat`.
  - Bit index = len-1, pass counter = 0.
  - Clears `match_cnt` and the 3-bit history register.
  - Illegal `len` (0 or >WIDTH): `start` is ignored and no outputs change.
- **SHIFT**, each cycle:
  - `out` = latched pattern[bit index], `out_valid`=1, `busy`=1.
  - Index decrements. At index 0, the pass counter increments and the index reloads to len-1.
  - After the last bit of the final pass, the state returns to IDLE.
- **Ignored inputs while SHIFT:** `start` and all inputs have no effect. Latched values are used.
- **Match counter**
  - Updates at the same edge that drives each `out` bit.
  - Compares {history[2:0], new bit} against 4'b1101, so overlapping matches count.
  - History shifts the new bit in.
  - The count includes bits that span pass boundaries within one transaction.
  - History does not carry across transactions.
  - Saturates at 255.
  - Holds its value in IDLE until the next accepted start.
- **IDLE outputs:** `out`=0, `out_valid`=0, `busy`=0.
- **Reset:**
  - `out`, `out_valid`, `busy`, `done` = 0; `match_cnt` = 0; history = 0; state = IDLE.
  - Reset during SHIFT aborts the transaction immediately, and no `done` is issued.
  - Reset has priority over `start`.

## Timing
- Start accepted at edge k. The first bit appears on `out` after edge k, i.e. in cycle k+1.
- `out_valid` is high for exactly len×(repeat+1) consecutive cycles, with no gaps between passes.
- The last bit occupies cycle k+N, where N = len×(repeat+1).
- In cycle k+N+1: `done`=1, `busy`=0, `out_valid`=0, `out`=0, and `match_cnt` is final.
- `done` is high for one cycle only.
- A `start` sampled at the end of the `done` cycle is accepted. Back-to-back transactions therefore have a one-cycle idle gap.
- Maximum transaction: WIDTH×2^REP_W bits.
- `match_cnt` is valid in the same cycle as the `out` bit that completed the match. The detector's Moore `out` asserts one cycle later, so the bench compares hit totals after `done`.

## Test plan
- **Single pass:** `pattern`=16'h000D, `len`=4, `repeat`=0, `start` pulse → `out`=1,1,0,1 in cycles 1–4 with `out_valid`=1; `done` in cycle 5; `match_cnt`=1.
- **Overlap:** `pattern`=8'b0110_1101, `len`=8 → `out` 0,1,1,0,1,1,0,1; `match_cnt`=2; `done` after 8 bits.
- **Repeat across pass boundary:** `pattern`=4'b1101, `len`=4, `repeat`=2 → 12 contiguous bits "110111011101"; `match_cnt`=3; `done` in cycle 13.
- **Illegal or busy start:** `len`=0 or 17 with `start` → no `busy`, all outputs stay 0. `start` pulsed mid-SHIFT → stream and count unchanged.
- **Reset mid-operation:** `reset` at bit 2 of a 16-bit transaction → next cycle `out`=0, `out_valid`=0, `busy`=0, `match_cnt`=0, no `done`. A new `start` afterwards runs normally.
- **Back-to-back:** `start` held high continuously with `len`=4 → second transaction's first bit appears 2 cycles after the first's last bit; `match_cnt` restarts from 0.
